// File: rtl/colour_bbox_tracker.sv
// Multi-channel colour bounding-box tracker: classifies video pixels into RGB windows,
// accumulates per-channel boxes and counts, and reports them on a valid/ready stream.
module colour_bbox_tracker #(
  parameter int unsigned NUM_COLOURS  = 4,
  parameter int unsigned IMAGE_W      = 640,
  parameter int unsigned IMAGE_H      = 480,
  parameter int unsigned COORD_W      = 11,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MSG_INTERVAL = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sop,
  input  logic        pix_eop,
  output logic [31:0] msg_data,
  output logic        msg_valid,
  input  logic        msg_ready,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [4:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        overrun
);

  localparam int unsigned CH_W = 4;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMAGE_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMAGE_H - 1);
  localparam logic [COORD_W-1:0] Y_END  = COORD_W'(IMAGE_H);
  localparam logic [31:0] ID_WORD  = 32'h1234EEE3;
  localparam logic [31:0] END_WORD = 32'h454E4421;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_TL, S_BR, S_NEXT, S_END} state_t;

  logic               enable_q, overrun_q;
  logic [7:0]         interval_q, frame_cnt_q;
  logic [CNT_W-1:0]   min_count_q;
  logic [23:0]        lo_q [NUM_COLOURS];
  logic [23:0]        hi_q [NUM_COLOURS];
  logic [31:0]        readdata_q, rd_data;

  logic               packet_video_q;
  logic [COORD_W-1:0] x_q, y_q;

  logic [COORD_W-1:0] xmin_q [NUM_COLOURS], xmax_q [NUM_COLOURS];
  logic [COORD_W-1:0] ymin_q [NUM_COLOURS], ymax_q [NUM_COLOURS];
  logic [CNT_W-1:0]   cnt_q  [NUM_COLOURS];
  logic [COORD_W-1:0] xmin_d [NUM_COLOURS], xmax_d [NUM_COLOURS];
  logic [COORD_W-1:0] ymin_d [NUM_COLOURS], ymax_d [NUM_COLOURS];
  logic [CNT_W-1:0]   cnt_d  [NUM_COLOURS];
  logic [COORD_W-1:0] sxmin_q [NUM_COLOURS], sxmax_q [NUM_COLOURS];
  logic [COORD_W-1:0] symin_q [NUM_COLOURS], symax_q [NUM_COLOURS];
  logic [CNT_W-1:0]   scnt_q  [NUM_COLOURS];

  state_t             state_q;
  logic [CH_W-1:0]    ch_q;
  logic               msg_valid_q;
  logic [31:0]        msg_data_q;

  logic               wr, rd, pix_beat, pixel_en, frame_end, report_go, start, drop, xfer;
  logic               hit;
  logic [CH_W-1:0]    hit_ch;
  logic [COORD_W-1:0] sel_xmin, sel_xmax, sel_ymin, sel_ymax;
  logic [CNT_W-1:0]   sel_cnt;
  logic               unused_wdata;

  function automatic logic in_window(input logic [23:0] p, input logic [23:0] lo,
                                     input logic [23:0] hi);
    return (p[23:16] >= lo[23:16]) && (p[23:16] <= hi[23:16]) &&
           (p[15:8]  >= lo[15:8])  && (p[15:8]  <= hi[15:8])  &&
           (p[7:0]   >= lo[7:0])   && (p[7:0]   <= hi[7:0]);
  endfunction

  assign wr           = s_chipselect & s_write;
  assign rd           = s_chipselect & s_read;
  assign pix_beat     = pix_valid & ~pix_sop & packet_video_q;
  assign pixel_en     = pix_beat & (y_q < Y_END);
  assign frame_end    = pix_beat & pix_eop;
  assign report_go    = frame_end & enable_q & (frame_cnt_q == '0);
  assign start        = report_go & (state_q == S_IDLE);
  assign drop         = report_go & (state_q != S_IDLE);
  assign xfer         = msg_valid_q & msg_ready;
  assign unused_wdata = ^s_writedata[31:24];

  assign msg_data   = msg_data_q;
  assign msg_valid  = msg_valid_q;
  assign s_readdata = readdata_q;
  assign overrun    = overrun_q;

  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int unsigned c = 0; c < NUM_COLOURS; c++) begin
      if (!hit && in_window(pix_data, lo_q[c], hi_q[c])) begin
        hit    = 1'b1;
        hit_ch = CH_W'(c);
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_COLOURS; c++) begin
      xmin_d[c] = xmin_q[c];
      xmax_d[c] = xmax_q[c];
      ymin_d[c] = ymin_q[c];
      ymax_d[c] = ymax_q[c];
      cnt_d[c]  = cnt_q[c];
      if (pixel_en && hit && hit_ch == CH_W'(c)) begin
        if (x_q < xmin_q[c]) xmin_d[c] = x_q;
        if (x_q > xmax_q[c]) xmax_d[c] = x_q;
        if (y_q < ymin_q[c]) ymin_d[c] = y_q;
        if (y_q > ymax_q[c]) ymax_d[c] = y_q;
        if (cnt_q[c] != '1)  cnt_d[c]  = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      packet_video_q <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
    end else if (pix_valid && pix_sop) begin
      packet_video_q <= (pix_data[3:0] == 4'h0);
      x_q            <= '0;
      y_q            <= '0;
    end else if (pix_valid && (y_q < Y_END)) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= y_q + COORD_W'(1);
      end else begin
        x_q <= x_q + COORD_W'(1);
      end
    end
  end

  // The snapshot is frozen while a report is being serialised, so a dropped
  // report never corrupts the one in flight.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_COLOURS; c++) begin
      if (reset || frame_end) begin
        xmin_q[c] <= X_LAST;
        ymin_q[c] <= Y_LAST;
        xmax_q[c] <= '0;
        ymax_q[c] <= '0;
        cnt_q[c]  <= '0;
      end else begin
        xmin_q[c] <= xmin_d[c];
        ymin_q[c] <= ymin_d[c];
        xmax_q[c] <= xmax_d[c];
        ymax_q[c] <= ymax_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      if (reset) begin
        sxmin_q[c] <= X_LAST;
        symin_q[c] <= Y_LAST;
        sxmax_q[c] <= '0;
        symax_q[c] <= '0;
        scnt_q[c]  <= '0;
      end else if (frame_end && state_q == S_IDLE) begin
        sxmin_q[c] <= xmin_d[c];
        symin_q[c] <= ymin_d[c];
        sxmax_q[c] <= xmax_d[c];
        symax_q[c] <= ymax_d[c];
        scnt_q[c]  <= cnt_d[c];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (s_address)
      5'd0:    rd_data = {30'b0, overrun_q, enable_q};
      5'd1:    rd_data = ID_WORD;
      5'd2:    rd_data = {24'b0, interval_q};
      5'd3:    rd_data = 32'(min_count_q);
      default: begin
        for (int unsigned c = 0; c < NUM_COLOURS; c++) begin
          if (s_address == 5'(4 + 2 * c)) rd_data = {8'h00, lo_q[c]};
          if (s_address == 5'(5 + 2 * c)) rd_data = {8'h00, hi_q[c]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q    <= 1'b1;
      overrun_q   <= 1'b0;
      interval_q  <= 8'(MSG_INTERVAL);
      frame_cnt_q <= 8'(MSG_INTERVAL - 1);
      min_count_q <= CNT_W'(1);
      readdata_q  <= '0;
      for (int unsigned c = 0; c < NUM_COLOURS; c++) begin
        lo_q[c] <= '1;
        hi_q[c] <= '0;
      end
    end else begin
      if (rd) readdata_q <= rd_data;
      if (drop)                                     overrun_q <= 1'b1;
      else if (wr && s_address == 5'd0 && s_writedata[1]) overrun_q <= 1'b0;
      if (wr) begin
        if (s_address == 5'd0) enable_q    <= s_writedata[0];
        if (s_address == 5'd2) interval_q  <= s_writedata[7:0];
        if (s_address == 5'd3) min_count_q <= s_writedata[CNT_W-1:0];
        for (int unsigned c = 0; c < NUM_COLOURS; c++) begin
          if (s_address == 5'(4 + 2 * c)) lo_q[c] <= s_writedata[23:0];
          if (s_address == 5'(5 + 2 * c)) hi_q[c] <= s_writedata[23:0];
        end
      end
      // Writing the interval restarts the frame countdown from the new value.
      if (wr && s_address == 5'd2) begin
        frame_cnt_q <= s_writedata[7:0] - 8'd1;
      end else if (frame_end) begin
        if (frame_cnt_q != '0) frame_cnt_q <= frame_cnt_q - 8'd1;
        else if (enable_q)     frame_cnt_q <= interval_q - 8'd1;
      end
    end
  end

  always_comb begin
    sel_xmin = '0;
    sel_xmax = '0;
    sel_ymin = '0;
    sel_ymax = '0;
    sel_cnt  = '0;
    for (int unsigned c = 0; c < NUM_COLOURS; c++) begin
      if (ch_q == CH_W'(c)) begin
        sel_xmin = sxmin_q[c];
        sel_xmax = sxmax_q[c];
        sel_ymin = symin_q[c];
        sel_ymax = symax_q[c];
        sel_cnt  = scnt_q[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      msg_valid_q <= 1'b0;
      msg_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_NEXT;
          ch_q    <= '0;
        end
        S_NEXT: begin
          if (ch_q == CH_W'(NUM_COLOURS)) begin
            state_q     <= S_END;
            msg_valid_q <= 1'b1;
            msg_data_q  <= END_WORD;
          end else if (sel_cnt >= min_count_q) begin
            state_q     <= S_HDR;
            msg_valid_q <= 1'b1;
            msg_data_q  <= {8'h42, 8'(ch_q), 16'(sel_cnt)};
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
        end
        S_HDR: if (xfer) begin
          state_q    <= S_TL;
          msg_data_q <= {16'(sel_xmin), 16'(sel_ymin)};
        end
        S_TL: if (xfer) begin
          state_q    <= S_BR;
          msg_data_q <= {16'(sel_xmax), 16'(sel_ymax)};
        end
        S_BR: if (xfer) begin
          state_q     <= S_NEXT;
          msg_valid_q <= 1'b0;
          ch_q        <= ch_q + CH_W'(1);
        end
        S_END: if (xfer) begin
          state_q     <= S_IDLE;
          msg_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_colour_bbox_tracker.sv
// Scoreboard bench for colour_bbox_tracker: directed frames with hand-computed report words.
`timescale 1ns/1ps
module tb_colour_bbox_tracker;
  localparam int W = 320;
  localparam int H = 96;
  localparam logic [31:0] END_W = 32'h454E4421;
  localparam logic [23:0] RED   = 24'hFF0000;

  logic        clk = 1'b0, reset = 1'b1;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0, pix_sop = 1'b0, pix_eop = 1'b0;
  logic [31:0] msg_data;
  logic        msg_valid;
  logic        msg_ready = 1'b1;
  logic        s_chipselect = 1'b0, s_read = 1'b0, s_write = 1'b0;
  logic [4:0]  s_address = '0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        overrun;

  always #5 clk = ~clk;

  colour_bbox_tracker #(
    .NUM_COLOURS(4), .IMAGE_W(W), .IMAGE_H(H), .COORD_W(11), .CNT_W(10), .MSG_INTERVAL(6)
  ) dut (
    .clk(clk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sop(pix_sop), .pix_eop(pix_eop), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .s_chipselect(s_chipselect), .s_read(s_read),
    .s_write(s_write), .s_address(s_address), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .overrun(overrun)
  );

  int          total = 0, bad = 0;
  logic [31:0] sb_q[$];
  int          hit_idx[$];
  logic [23:0] hit_col[$];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && msg_valid && msg_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_msg got=%h exp=none", msg_data);
      end else begin
        check("msg_word", msg_data, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    tick();
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    tick();
    s_chipselect = 1'b0; s_read = 1'b0;
    check(name, s_readdata, exp);
  endtask

  task automatic px(input int x, input int y, input logic [23:0] col);
    hit_idx.push_back(y * W + x);
    hit_col.push_back(col);
  endtask

  task automatic expect_ch(input logic [31:0] hdr, input logic [31:0] tl, input logic [31:0] br);
    sb_q.push_back(hdr);
    sb_q.push_back(tl);
    sb_q.push_back(br);
  endtask

  task automatic run_frame(input int nbeats, input logic [3:0] ptype, input logic [23:0] fill);
    pix_valid = 1'b1; pix_sop = 1'b1; pix_eop = 1'b0; pix_data = {20'h0, ptype};
    tick();
    for (int i = 0; i < nbeats; i++) begin
      logic [23:0] c;
      c = fill;
      for (int k = 0; k < hit_idx.size(); k++) if (hit_idx[k] == i) c = hit_col[k];
      pix_sop = 1'b0; pix_eop = (i == nbeats - 1); pix_data = c;
      tick();
    end
    pix_valid = 1'b0; pix_eop = 1'b0; pix_data = '0;
    hit_idx.delete();
    hit_col.delete();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s timeout pending=%0d exp=0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (10) tick();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!msg_valid && n < 100) begin
      tick();
      n++;
    end
    check(name, {31'b0, msg_valid}, 32'd1);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_msg_valid", {31'b0, msg_valid}, 32'd0);
    check("rst_msg_data", msg_data, 32'd0);
    check("rst_readdata", s_readdata, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    reg_rd(5'd0, 32'd1, "rst_ctrl");
    reg_rd(5'd1, 32'h1234EEE3, "id");
    reg_rd(5'd2, 32'd6, "rst_interval");
    reg_rd(5'd3, 32'd1, "rst_min_count");
    reg_rd(5'd4, 32'h00FFFFFF, "rst_lo0");
    reg_rd(5'd5, 32'h0, "rst_hi0");
    reg_rd(5'd12, 32'h0, "unmapped12");
    reg_rd(5'd31, 32'h0, "unmapped31");

    // Default interval: reports on video frames 6 and 12; non-video packet ignored.
    reg_wr(5'd4, {8'h0, RED});
    reg_wr(5'd5, {8'h0, RED});
    for (int f = 1; f <= 12; f++) begin
      if (f == 6) begin
        px(0, 0, RED); px(1, 0, RED); px(2, 0, RED);
        run_frame(3, 4'h3, 24'h0);
        expect_ch(32'h42000001, 32'h00020000, 32'h00020000);
        sb_q.push_back(END_W);
        px(2, 0, RED);
        run_frame(3, 4'h0, 24'h0);
        wait_drain("frame6");
      end else if (f == 12) begin
        expect_ch(32'h42000001, 32'h00010000, 32'h00010000);
        sb_q.push_back(END_W);
        px(1, 0, RED);
        run_frame(2, 4'h0, 24'h0);
        wait_drain("frame12");
      end else begin
        px(0, 0, RED);
        run_frame(1, 4'h0, 24'h0);
        repeat (8) tick();
      end
    end

    // Two red pixels far apart, interval 1.
    reg_wr(5'd2, 32'd1);
    reg_rd(5'd2, 32'd1, "interval_wr");
    expect_ch(32'h42000002, 32'h00640014, 32'h012C005A);
    sb_q.push_back(END_W);
    px(100, 20, RED); px(300, 90, RED);
    run_frame(90 * W + 301, 4'h0, 24'h0);
    wait_drain("two_red");

    // Line wrap boundary plus inclusive window edges on channel 1.
    reg_wr(5'd6, 32'h00101010);
    reg_wr(5'd7, 32'h00202020);
    expect_ch(32'h42000002, 32'h00000000, 32'h013F0001);
    expect_ch(32'h42010002, 32'h00000000, 32'h00010000);
    sb_q.push_back(END_W);
    px(0, 0, 24'h101010); px(1, 0, 24'h202020); px(2, 0, 24'h0F1010); px(3, 0, 24'h202120);
    px(W - 1, 0, RED); px(0, 1, RED);
    run_frame(W + 1, 4'h0, 24'h0);
    wait_drain("wrap_incl");

    // Overlapping windows: lowest index wins.
    reg_wr(5'd5, 32'h00FFFF00);
    reg_wr(5'd6, 32'h00FFFF00);
    reg_wr(5'd7, 32'h00FFFF00);
    expect_ch(32'h42000002, 32'h00000000, 32'h00010000);
    sb_q.push_back(END_W);
    px(0, 0, 24'hFFFF00); px(1, 0, 24'hFF8000);
    run_frame(2, 4'h0, 24'h0);
    wait_drain("priority");

    // Back-pressure for 10 cycles on the second word.
    begin
      int n = 0;
      expect_ch(32'h42000001, 32'h00030000, 32'h00030000);
      sb_q.push_back(END_W);
      px(3, 0, RED);
      run_frame(5, 4'h0, 24'h0);
      while (sb_q.size() > 3 && n < 100) begin
        tick();
        n++;
      end
      msg_ready = 1'b0;
      repeat (10) begin
        @(negedge clk);
        check("stall_valid", {31'b0, msg_valid}, 32'd1);
        check("stall_data", msg_data, sb_q[0]);
      end
      @(posedge clk);
      #1;
      msg_ready = 1'b1;
      wait_drain("stall");
    end

    // Second frame while the first report is stalled: dropped, overrun set.
    msg_ready = 1'b0;
    expect_ch(32'h42000001, 32'h00040000, 32'h00040000);
    sb_q.push_back(END_W);
    px(4, 0, RED);
    run_frame(5, 4'h0, 24'h0);
    wait_valid("report_a_valid");
    px(1, 0, RED);
    run_frame(2, 4'h0, 24'h0);
    tick();
    check("overrun_out", {31'b0, overrun}, 32'd1);
    reg_rd(5'd0, 32'd3, "ctrl_overrun");
    msg_ready = 1'b1;
    wait_drain("report_a");
    reg_wr(5'd0, 32'd2);
    reg_rd(5'd0, 32'd0, "ctrl_cleared");
    check("overrun_clr", {31'b0, overrun}, 32'd0);
    px(0, 0, RED);
    run_frame(1, 4'h0, 24'h0);
    repeat (30) tick();
    reg_wr(5'd0, 32'd1);

    // Count saturation at CNT_W=10.
    expect_ch(32'h420003FF, 32'h00000000, 32'h013F0003);
    sb_q.push_back(END_W);
    run_frame(1100, 4'h0, RED);
    wait_drain("saturate");

    // Channel below min_count is skipped; END still sent.
    reg_wr(5'd3, 32'd3);
    reg_rd(5'd3, 32'd3, "min_count_wr");
    sb_q.push_back(END_W);
    px(0, 0, RED); px(1, 0, RED);
    run_frame(2, 4'h0, 24'h0);
    wait_drain("min_count");

    // Reset in the middle of a report; no frame counted without a new sop.
    msg_ready = 1'b0;
    reg_wr(5'd3, 32'd1);
    px(0, 0, RED);
    run_frame(1, 4'h0, 24'h0);
    wait_valid("pre_reset_valid");
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    sb_q.delete();
    tick();
    check("mid_rst_valid", {31'b0, msg_valid}, 32'd0);
    check("mid_rst_data", msg_data, 32'd0);
    reg_rd(5'd4, 32'h00FFFFFF, "mid_rst_lo0");
    msg_ready = 1'b1;
    reg_wr(5'd2, 32'd1);
    pix_valid = 1'b1; pix_eop = 1'b1; pix_data = '0;
    tick();
    pix_valid = 1'b0; pix_eop = 1'b0;
    repeat (30) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/colour_bbox_tracker.md
Name: colour_bbox_tracker

Overview:
- Multi-channel successor to the single-pipeline colour detector.
- Taps the processed pixel stream after the input stream register; observes only, never back-pressures.
- Classifies each video pixel into one of NUM_COLOURS register-programmed RGB windows and accumulates a bounding box and pixel count per channel.
- At each reported frame end, serialises per-channel results onto a valid/ready message stream feeding the CPU message FIFO.

Parameters:
- NUM_COLOURS, 4: number of colour channels, 1..12.
- IMAGE_W, 640: pixels per line.
- IMAGE_H, 480: lines per frame.
- COORD_W, 11: coordinate width.
- CNT_W, 16: per-channel pixel count width; saturating.
- MSG_INTERVAL, 6: default frames between reports; reset value of reg 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_data  in  24  {R[23:16],G[15:8],B[7:0]}
- pix_valid  in  1  beat valid
- pix_sop  in  1  start of packet
- pix_eop  in  1  end of packet
- msg_data  out  32  message word
- msg_valid  out  1  message word valid
- msg_ready  in  1  sink accepts word
- s_chipselect  in  1  mm slave select
- s_read  in  1  mm read
- s_write  in  1  mm write
- s_address  in  5  mm word address
- s_writedata  in  32  mm write data
- s_readdata  out  32  mm read data, registered
- overrun  out  1  sticky: frame report dropped

Behaviour:
- Reset: msg_valid=0, msg_data=0, s_readdata=0, overrun=0, FSM IDLE, accumulators cleared.
- Reset registers: enable=1, interval=MSG_INTERVAL, min_count=1, all windows lo=FFFFFF / hi=000000 (empty window, matches nothing).
- Register map:
  - 0 ctrl: bit0 enable (RW); bit1 overrun (read; write 1 clears).
  - 1 ID, read-only: 32'h1234EEE3.
  - 2 interval[7:0].
  - 3 min_count[CNT_W-1:0].
  - 4+2c: lo window {R,G,B}[23:0].
  - 5+2c: hi window.
  - Unmapped reads return 0.
- s_readdata updates one cycle after s_chipselect&s_read.
- Packet type: on a valid sop beat, packet_video <= (pix_data[3:0]==0). The sop beat is never a pixel.
- Coordinates:
  - x,y cleared on sop and advanced on each valid non-sop beat.
  - When x==IMAGE_W-1: x<=0, y<=y+1.
  - Beats with y>=IMAGE_H are ignored.
- Classification:
  - Channel c matches when lo_c<=pixel<=hi_c for each of R, G and B independently (inclusive).
  - The lowest matching index wins; at most one channel updates per beat.
- Accumulation on a matching video pixel:
  - xmin=min, xmax=max, ymin=min, ymax=max.
  - count+1, saturating at all-ones.
- Frame end: on a valid eop of a video packet, all channels snapshot {xmin,ymin,xmax,ymax,count} and the accumulators clear in the same cycle.
  - Clear values: xmin=IMAGE_W-1, ymin=IMAGE_H-1, max=0, count=0.
  - An eop beat that is itself a matching pixel is included in the snapshot.
- frame_cnt:
  - Decrements at each video eop.
  - When it is 0 and enable=1, a report starts and frame_cnt reloads interval-1.
  - If the FSM is not IDLE at that point: the report is dropped, the snapshot is kept unchanged, overrun<=1, frame_cnt still reloads.
- Report FSM states and words:
  - IDLE.
  - HDR: word {8'h42, 8'(c), CNT_W'(count) zero-extended to 16}.
  - TL: {5'b0,xmin,5'b0,ymin}.
  - BR: {5'b0,xmax,5'b0,ymax}.
  - NEXT: c+1; from NEXT go to HDR, or to END after the last channel.
  - END: word 32'h454E4421 ("END!"), then IDLE.
- Channel skip: channels with count<min_count are skipped (NEXT directly, no words). END is always emitted.
- Handshake:
  - A word is transferred when msg_valid&msg_ready; the FSM advances only on transfer.
  - msg_data stays stable while msg_valid=1 and msg_ready=0.
  - No combinational path from msg_ready to msg_valid.
- Disabling: enable=0 stops new reports; an in-progress report completes.
- Reset mid-frame or mid-report: everything returns to reset state; packet_video=0 until the next sop.

Test Plan:
- Window 0 = FF0000..FF0000, interval=1. Frame with pure red pixels at (100,20) and (300,90), else black → message HDR 42000002, TL 00640014, BR 012C005A, END 454E4421.
- Pixel FFFF00 matching both window 0 (FF0000..FFFF00) and window 1 (FFFF00..FFFF00) → only channel 0 counts; channel 1 skipped.
- msg_ready held low 10 cycles mid-report → msg_data unchanged for all 10 cycles, no words lost or duplicated.
- interval=1 with msg_ready=0 across two frames → first report stalls, second dropped; overrun=1, reg0 bit1 reads 1; write 2 to reg0 → reads 0.
- 70000 matching pixels on channel 0 (CNT_W=16) → count saturates at FFFF; HDR 4200FFFF.
- Non-video packet (sop data nibble 3) containing matching pixels → no accumulation and no report; MSG_INTERVAL default → reports on frames 6, 12.
